// File: rtl/sram_pkg.sv
// Shared parameters, FSM encoding and length helper for the SRAM writer.
package sram_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 1024;
    localparam int ADDR_W_DEF = 13;
    localparam int LEN_W      = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [LEN_W-1:0] clamp_len(
        input logic [LEN_W-1:0] len,
        input logic [LEN_W-1:0] max_len
    );
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/sram_writer_if.sv
// Valid/ready beat stream feeding the SRAM writer.
interface sram_writer_if
    import sram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/sram_1w.sv
// Single write-port word array with an asynchronous read port,
// used as the write-side model of the input buffer.
module sram_1w
    import sram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     clock,
    input  logic [ADDR_W-1:0]        WriteAddress,
    input  logic [DATA_W-1:0]        WriteBus,
    input  logic                     WriteEnable,
    input  logic [$clog2(DEPTH)-1:0] ReadAddress,
    output logic [DATA_W-1:0]        ReadData
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Out-of-range addresses are dropped rather than aliased.
    always_ff @(posedge clock) begin
        if (WriteEnable && (WriteAddress < ADDR_W'(DEPTH))) begin
            r_mem[WriteAddress[IDX_W-1:0]] <= WriteBus;
        end
    end

    assign ReadData = r_mem[ReadAddress];

endmodule

// File: rtl/sram_writer.sv
// Burst loader: accepts a stream of beats and writes them to
// consecutive, wrapping SRAM addresses with one cycle of latency.
module sram_writer
    import sram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    sram_writer_if.slave      s_in,
    output logic [ADDR_W-1:0] WriteAddress,
    output logic [DATA_W-1:0] WriteBus,
    output logic              WriteEnable,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  count
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t            r_state;
    state_t            w_next;
    logic [IDX_W-1:0]  r_ptr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_count;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_start_ok;
    logic              w_accept;
    logic              w_last;
    logic [LEN_W-1:0]  w_len_in;
    logic [LEN_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  w_ptr_nxt;
    logic              w_unused;

    // Upper base bits never reach the address; the burst stays in-array.
    assign w_unused   = ^base_addr[ADDR_W-1:IDX_W];

    assign w_len_in   = clamp_len(length, LEN_W'(DEPTH));
    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_accept   = s_in.in_valid && s_in.in_ready;
    assign w_cnt_nxt  = r_count + LEN_W'(1);
    assign w_last     = w_accept && (w_cnt_nxt == r_len);
    assign w_ptr_nxt  = (r_ptr == IDX_W'(DEPTH - 1)) ? '0
                                                     : r_ptr + IDX_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (w_len_in == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_last) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr   <= '0;
            r_len   <= '0;
            r_count <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_accept;
            if (w_start_ok) begin
                r_ptr   <= base_addr[IDX_W-1:0];
                r_len   <= w_len_in;
                r_count <= '0;
            end else if (w_accept) begin
                r_ptr   <= w_ptr_nxt;
                r_count <= w_cnt_nxt;
                r_waddr <= ADDR_W'(r_ptr);
                r_wdata <= s_in.in_data;
            end
        end
    end

    assign s_in.in_ready = (r_state == ST_LOAD);
    assign WriteAddress  = r_waddr;
    assign WriteBus      = r_wdata;
    assign WriteEnable   = r_we;
    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_DONE);
    assign count         = r_count;

endmodule

// File: doc/sram_writer.md
SRAM_WRITER -- requirements
Module: sram_writer

Interface
REQ-001 Parameter DATA_W, default 8, memory word width in bits.
REQ-002 Parameter DEPTH, default 1024, number of memory words.
REQ-003 Parameter ADDR_W, default 13, write-address port width.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a load burst; sampled only in IDLE.
REQ-007 base_addr  input  ADDR_W  first word address of the burst, sampled with start.
REQ-008 length  input  11  number of words in the burst (0..1024), sampled with start.
REQ-009 in_data  input  DATA_W  write data beat.
REQ-010 in_valid  input  1  in_data is valid.
REQ-011 in_ready  output  1  block accepts a beat this cycle.
REQ-012 WriteAddress  output  ADDR_W  memory write address.
REQ-013 WriteBus  output  DATA_W  memory write data.
REQ-014 WriteEnable  output  1  memory write strobe, one word per high cycle.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse when a burst completes.
REQ-017 count  output  11  words written in the current or most recent burst.

Function
REQ-018 FSM states IDLE, LOAD, DRAIN, DONE; state is registered.
REQ-019 IDLE: start=1 and length>0 -> LOAD; start=1 and length=0 -> DONE; else stay.
REQ-020 LOAD: in_ready=1; a beat is accepted on any edge with in_valid=1 and in_ready=1.
REQ-021 LOAD: accepting the length-th beat -> DRAIN; in_ready=0 in DRAIN, DONE and IDLE.
REQ-022 DRAIN -> DONE unconditionally after one cycle; DONE -> IDLE unconditionally after one cycle.
REQ-023 Write latency is one cycle: a beat accepted at edge N drives WriteEnable=1, WriteBus=in_data, WriteAddress=its address during cycle N+1; WriteAddress, WriteBus and WriteEnable are registered.
REQ-024 WriteEnable=0 in any cycle following an edge with no accepted beat; in_valid gaps stall without loss or duplication.
REQ-025 Address of k-th beat (k from 0) = (base_addr[9:0] + k) mod DEPTH; WriteAddress[12:10] always 0.
REQ-026 Addresses wrap from DEPTH-1 to 0 within a burst; no error is flagged.
REQ-027 count clears to 0 on accepted start, increments by 1 per accepted beat, holds after DONE until the next start.
REQ-028 done=1 only in DONE state; for length>0 done rises the cycle after the final WriteEnable cycle.
REQ-029 length>1024 is clamped to 1024.
REQ-030 start asserted outside IDLE is ignored; base_addr and length are latched only on an accepted start.

Reset
REQ-031 On reset=1 at an edge: state=IDLE, in_ready=0, WriteEnable=0, WriteAddress=0, WriteBus=0, busy=0, done=0, count=0.
REQ-032 Reset mid-burst aborts: no WriteEnable in the cycle after the reset edge, a beat presented in the reset cycle is not accepted, and no done pulse is produced.
REQ-033 reset has priority over start and in_valid at the same edge.

Structure
REQ-034 DATA_W, DEPTH, ADDR_W defaults and the FSM state encoding live in shared package sram_pkg.
REQ-035 One sub-module, sram_1w (DEPTH x DATA_W array, write port: WriteAddress, WriteBus, WriteEnable), is instantiated only in the verification bench as the write-side model of the input buffer; sram_writer contains no storage array.

Verification
REQ-036 Basic: base=0, length=4, beats 0xA1..0xA4, in_valid held high -> WE at addr 0..3 in four consecutive cycles, done one cycle after the last WE, count=4.
REQ-037 Wrap: base=1022, length=4 -> writes to addresses 1022, 1023, 0, 1; WriteAddress[12:10]=0 throughout.
REQ-038 Stall: length=3, in_valid pattern 1,0,0,1,1 -> exactly 3 writes, WE low in the two gap cycles, data order preserved.
REQ-039 Zero length: start with length=0 -> busy for one cycle, done pulse, no WE, count=0.
REQ-040 Abort: reset asserted after 2 of 5 beats -> no further WE, in_ready=0 and count=0 after the edge, no done pulse; a following start with base=10, length=1 -> single write at address 10.
REQ-041 Ignored start: start with base=500 pulsed during LOAD of base=0, length=2 -> writes only at addresses 0 and 1.
